// File: rtl/wave_capture_pkg.sv
// Shared widths, capture length and FSM encoding for the wave capture block.
package wave_capture_pkg;

    localparam int unsigned WC_SAMPLE_WIDTH  = 16;
    localparam int unsigned WC_ADDR_WIDTH    = 9;
    localparam int unsigned WC_VALUE_WIDTH   = 8;
    localparam int unsigned WC_CAPTURE_LEN   = 256;
    localparam int unsigned WC_OFFSET_WIDTH  = $clog2(WC_CAPTURE_LEN);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam int unsigned WC_STATE_WIDTH = $bits(state_t);

endpackage

// File: rtl/wave_capture_dffr.sv
// Register cells: dffr (sync active-high reset) and dffre (same, with load enable).
module dffr #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (reset) o_q <= '0;
        else       o_q <= i_d;
    end

endmodule

module dffre #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (reset)     o_q <= '0;
        else if (i_en) o_q <= i_d;
    end

endmodule

// File: rtl/wave_capture_zero_cross_detect.sv
// Positive-going zero-crossing detector: remembers the sign of the last strobed sample.
module zero_cross_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_strobe,
    input  logic i_sign,
    output logic o_cross_c
);

    logic r_prev_sign;

    dffre #(.WIDTH(1)) u_prev_sign (
        .clk   (clk),
        .reset (reset),
        .i_en  (i_strobe),
        .i_d   (i_sign),
        .o_q   (r_prev_sign)
    );

    // Zero counts as non-negative, so negative -> zero is a crossing.
    assign o_cross_c = i_strobe & r_prev_sign & ~i_sign;

endmodule

// File: rtl/wave_capture.sv
// Captures one 256-sample trigger-aligned waveform into the hidden RAM bank,
// then swaps banks once the display goes idle.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = WC_SAMPLE_WIDTH,
    parameter int unsigned ADDR_WIDTH   = WC_ADDR_WIDTH,
    parameter int unsigned VALUE_WIDTH  = WC_VALUE_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
    input  logic                    wave_display_idle,
    output logic [ADDR_WIDTH-1:0]   write_address,
    output logic                    write_enable,
    output logic [VALUE_WIDTH-1:0]  write_sample,
    output logic                    read_index
);

    localparam int unsigned OFFSET_W = ADDR_WIDTH - 1;

    logic [WC_STATE_WIDTH-1:0] r_state_q;
    state_t                    w_state;
    state_t                    w_state_nxt;
    logic [OFFSET_W-1:0]       r_count;
    logic [OFFSET_W-1:0]       w_count_nxt;
    logic                      r_read_index;
    logic                      w_read_index_nxt;
    logic                      w_we;
    logic                      w_cross;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [VALUE_WIDTH-1:0]    w_sample;
    logic                      w_unused_low;

    zero_cross_detect u_zcd (
        .clk       (clk),
        .reset     (reset),
        .i_strobe  (new_sample_ready),
        .i_sign    (new_sample_in[SAMPLE_WIDTH-1]),
        .o_cross_c (w_cross)
    );

    dffr #(.WIDTH(WC_STATE_WIDTH)) u_state (
        .clk(clk), .reset(reset), .i_d(w_state_nxt), .o_q(r_state_q)
    );
    dffr #(.WIDTH(OFFSET_W)) u_count (
        .clk(clk), .reset(reset), .i_d(w_count_nxt), .o_q(r_count)
    );
    dffr #(.WIDTH(1)) u_read_index (
        .clk(clk), .reset(reset), .i_d(w_read_index_nxt), .o_q(r_read_index)
    );

    assign w_state = state_t'(r_state_q);

    // Next-state, capture counter and bank-swap decisions.
    always_comb begin
        w_state_nxt      = w_state;
        w_count_nxt      = r_count;
        w_read_index_nxt = r_read_index;
        w_we             = 1'b0;
        case (w_state)
            ST_ARMED: begin
                if (w_cross) begin
                    w_we        = 1'b1;
                    w_count_nxt = OFFSET_W'(1);
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    w_we        = 1'b1;
                    w_count_nxt = r_count + OFFSET_W'(1);
                    if (r_count == {OFFSET_W{1'b1}}) w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wave_display_idle) begin
                    w_read_index_nxt = ~r_read_index;
                    w_state_nxt      = ST_ARMED;
                end
            end
            default: begin
                w_state_nxt = ST_ARMED;
                w_count_nxt = '0;
            end
        endcase
    end

    // The trigger sample always lands at offset 0 of the hidden bank.
    assign w_addr   = {~r_read_index, (w_state == ST_ACTIVE) ? r_count : OFFSET_W'(0)};
    assign w_sample = {~new_sample_in[SAMPLE_WIDTH-1],
                       new_sample_in[SAMPLE_WIDTH-2 -: VALUE_WIDTH-1]};
    assign w_unused_low = ^new_sample_in[SAMPLE_WIDTH-VALUE_WIDTH-1:0];

    dffr #(.WIDTH(1)) u_we (
        .clk(clk), .reset(reset), .i_d(w_we), .o_q(write_enable)
    );
    dffre #(.WIDTH(ADDR_WIDTH)) u_addr (
        .clk(clk), .reset(reset), .i_en(w_we), .i_d(w_addr), .o_q(write_address)
    );
    dffre #(.WIDTH(VALUE_WIDTH)) u_sample (
        .clk(clk), .reset(reset), .i_en(w_we), .i_d(w_sample), .o_q(write_sample)
    );

    assign read_index = r_read_index;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: a behavioural capture model feeds a
// scoreboard queue of expected RAM writes that a negedge monitor consumes.
module tb_wave_capture;

    localparam int unsigned SW = 16;
    localparam int unsigned AW = 9;
    localparam int unsigned VW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          new_sample_ready = 1'b0;
    logic [SW-1:0] new_sample_in = '0;
    logic          wave_display_idle = 1'b0;
    logic [AW-1:0] write_address;
    logic          write_enable;
    logic [VW-1:0] write_sample;
    logic          read_index;

    always #5 clk = ~clk;

    wave_capture #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .VALUE_WIDTH(VW)) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    int checks   = 0;
    int errors   = 0;
    int n_writes = 0;

    logic [AW+VW-1:0] exp_q[$];
    logic [AW+VW-1:0] mon_exp;
    logic [AW-1:0]    last_addr = '0;
    logic [VW-1:0]    last_data = '0;

    // Reference model state: 0 armed, 1 active, 2 wait.
    int       m_state = 0;
    logic [7:0] m_count = 8'd0;
    logic     m_prev = 1'b0;
    logic     m_ri = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] disp(input logic [SW-1:0] v);
        logic [VW-1:0] b;
        b = v[SW-1 -: VW];
        return b ^ 8'h80;
    endfunction

    task automatic model_strobe(input logic [SW-1:0] v, input logic idle);
        logic sign;
        sign = v[SW-1];
        if (m_state == 0) begin
            if (m_prev && !sign) begin
                exp_q.push_back({~m_ri, 8'h00, disp(v)});
                m_count = 8'd1;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            exp_q.push_back({~m_ri, m_count, disp(v)});
            if (m_count == 8'hFF) m_state = 2;
            m_count = m_count + 8'd1;
        end else if (idle) begin
            m_ri    = ~m_ri;
            m_state = 0;
        end
        m_prev = sign;
    endtask

    task automatic drive(input logic [SW-1:0] v, input logic idle);
        @(negedge clk);
        new_sample_ready  = 1'b1;
        new_sample_in     = v;
        wave_display_idle = idle;
        model_strobe(v, idle);
        @(negedge clk);
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        #1 check("no_pending_write", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle_pulse();
        @(negedge clk);
        wave_display_idle = 1'b1;
        if (m_state == 2) begin
            m_ri    = ~m_ri;
            m_state = 0;
        end
        @(negedge clk);
        wave_display_idle = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        m_state = 0;
        m_count = 8'd0;
        m_prev  = 1'b0;
        m_ri    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Scoreboard: every write must be expected, and match in address and data.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            n_writes++;
            last_addr = write_address;
            last_data = write_sample;
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("write_payload", 32'({write_address, write_sample}), 32'(mon_exp));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_write_address", 32'(write_address), 32'd0);
        check("rst_write_sample", 32'(write_sample), 32'd0);
        check("rst_read_index", 32'(read_index), 32'd0);
        reset = 1'b0;

        // Positive samples only: must stay armed.
        drive(16'h1000, 1'b0);
        drive(16'h2000, 1'b0);
        check("armed_no_write", 32'(n_writes), 32'd0);

        // Negative then zero triggers capture at offset 0 of bank 1.
        drive(16'hF000, 1'b0);
        drive(16'h0000, 1'b0);
        check("trig_count", 32'(n_writes), 32'd1);
        check("trig_addr", 32'(last_addr), 32'h100);
        check("trig_data", 32'(last_data), 32'h80);

        for (int n = 1; n < 256; n++) drive(16'(n * 256), 1'b0);
        check("full_count", 32'(n_writes), 32'd256);
        check("full_last_addr", 32'(last_addr), 32'h1FF);
        check("full_last_data", 32'(last_data), 32'h7F);
        drive(16'h0100, 1'b0);
        check("wait_no_write", 32'(n_writes), 32'd256);
        check("wait_read_index", 32'(read_index), 32'd0);

        // Display idle swaps banks; next capture goes to bank 0.
        idle_pulse();
        check("swap_read_index", 32'(read_index), 32'd1);
        drive(16'h8000, 1'b0);
        drive(16'h7FFF, 1'b0);
        check("bank0_addr", 32'(last_addr), 32'h000);
        check("bank0_data", 32'(last_data), 32'hFF);

        // Idle is ignored while capturing.
        idle_pulse();
        check("active_idle_ignored", 32'(read_index), 32'd1);
        for (int n = 0; n < 9; n++) drive(16'(n * 16'h1111), 1'b0);
        check("partial_count", 32'(n_writes), 32'd266);

        // Reset mid-capture abandons it; a non-negative sample alone cannot re-arm.
        do_reset();
        check("mid_rst_read_index", 32'(read_index), 32'd0);
        check("mid_rst_write_enable", 32'(write_enable), 32'd0);
        drive(16'h0100, 1'b0);
        check("post_rst_no_write", 32'(n_writes), 32'd266);
        drive(16'hFFFF, 1'b0);
        drive(16'h0001, 1'b0);
        check("restart_addr", 32'(last_addr), 32'h100);
        check("restart_data", 32'(last_data), 32'h80);

        for (int n = 0; n < 255; n++) drive(16'($urandom_range(0, 65535)), 1'b0);
        check("second_full_count", 32'(n_writes), 32'd522);

        // Strobe coincident with the idle swap: not written, but its sign arms.
        drive(16'h8000, 1'b1);
        check("coinc_no_write", 32'(n_writes), 32'd522);
        check("coinc_read_index", 32'(read_index), 32'd1);
        drive(16'h0000, 1'b0);
        check("coinc_arm_count", 32'(n_writes), 32'd523);
        check("coinc_arm_addr", 32'(last_addr), 32'h000);
        check("coinc_arm_data", 32'(last_data), 32'h80);

        repeat (3) @(negedge clk);
        #1 check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16: width of the signed input audio sample.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: RAM address width, split as 1 bank bit plus 8 offset bits.
REQ-003 SHALL have parameter VALUE_WIDTH, default 8: width of a stored display sample.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
REQ-007 SHALL have port new_sample_in  input  SAMPLE_WIDTH  two's-complement audio sample.
REQ-008 SHALL have port wave_display_idle  input  1  high while the display is outside its active drawing region.
REQ-009 SHALL have port write_address  output  ADDR_WIDTH  sample RAM write address.
REQ-010 SHALL have port write_enable  output  1  sample RAM write strobe.
REQ-011 SHALL have port write_sample  output  VALUE_WIDTH  offset-binary sample to store.
REQ-012 SHALL have port read_index  output  1  RAM bank the display reads; wave_capture writes the other bank.

Function
REQ-013 SHALL implement a 3-state FSM with states ARMED, ACTIVE and WAIT.
REQ-014 SHALL hold prev_sign, the MSB of the most recent accepted sample; it updates on every new_sample_ready in every state.
REQ-015 ARMED: a strobe with prev_sign=1 and current MSB=0 (a positive-going zero crossing) SHALL move the FSM to ACTIVE and write that sample as offset 0.
- A sample value of exactly 0 counts as non-negative.
REQ-016 ACTIVE: each strobe SHALL write one sample at offset = count, then increment count.
- After the write at offset 255, the FSM SHALL enter WAIT and count SHALL wrap to 0.
REQ-017 WAIT: strobes SHALL be ignored, with no write.
- The first cycle with wave_display_idle=1 SHALL toggle read_index and return the FSM to ARMED.
REQ-018 write_address SHALL equal {~read_index, count[7:0]}; writes never target the bank being displayed.
REQ-019 write_sample SHALL equal new_sample_in[15:8] with the MSB inverted, i.e. signed value + 128. Examples: 0x8000→0x00, 0x0000→0x80, 0x7FFF→0xFF.
REQ-020 write_enable, write_address and write_sample SHALL be registered: asserted exactly one cycle after the accepted strobe, for exactly one cycle.
REQ-021 write_enable SHALL be 0 in every cycle that does not follow an accepted strobe.
REQ-022 If the idle toggle in WAIT coincides with a strobe, the strobe SHALL NOT be written.
- prev_sign SHALL still update from that strobe.
REQ-023 wave_display_idle SHALL be ignored in ARMED and ACTIVE.
- read_index SHALL change only on the WAIT→ARMED transition.

Reset
REQ-024 reset SHALL force: state=ARMED, count=0, prev_sign=0, read_index=0, write_enable=0, write_address=0, write_sample=0.
REQ-025 reset SHALL take priority over all inputs; asserted mid-ACTIVE it SHALL abandon the partial capture with no further writes.
REQ-026 After reset, the first capture SHALL require at least one negative sample before a non-negative one.

Structure
REQ-027 State encodings and the width constants (SAMPLE_WIDTH, ADDR_WIDTH, VALUE_WIDTH, 256-sample capture length) SHALL live in the shared package.
REQ-028 All state SHALL be held in the codebase's dffr/dffre register cells; no other sub-module is required.
REQ-029 A zero_cross_detect sub-module (prev_sign register plus edge compare) is the one natural split.

Verification
REQ-030 Reset, then strobes 0x1000, 0x2000 → no write_enable; state stays ARMED.
REQ-031 Strobes 0xF000 then 0x0000 → one cycle later write_enable=1, write_address=0x100, write_sample=0x80; state ACTIVE.
REQ-032 255 further strobes with values n·0x0100 → writes at 0x101..0x1FF; after the last write, the FSM is in WAIT; a 257th strobe produces no write.
REQ-033 In WAIT, raise wave_display_idle for 1 cycle → read_index=1.
- Next strobes 0x8000 then 0x7FFF → write at address 0x000, data 0xFF.
REQ-034 Assert reset after 10 ACTIVE writes → no further writes; read_index=0.
- A crossing 0xFFFF→0x0001 restarts capture at address 0x100.
REQ-035 Strobe coinciding with the idle toggle in WAIT → no write that cycle; that sample's sign still arms the next crossing.
